// File: rtl/alu_divider_iterative.sv
// ---------------------------------------------------------------------------
// alu_divider_iterative
//   Multi-cycle restoring radix-2 divider for the RV32M DIV, DIVU, REM and
//   REMU operations. It uses the integer ALU select codes 28..31. An
//   operation is issued with i_start while the unit is idle. o_busy stays
//   high until the o_done pulse, and o_rd holds the result until the next
//   accepted issue.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  issue request, sampled only while idle
//   i_sel    operation code (28=DIV 29=DIVU 30=REM 31=REMU), captured on issue
//   i_rs1    dividend, captured on issue
//   i_rs2    divisor, captured on issue
//   o_busy   high from the cycle after issue through the done cycle
//   o_done   one-cycle result-valid pulse
//   o_rd     result, valid from the done cycle until the next issue
// ---------------------------------------------------------------------------
module alu_divider_iterative #(
  parameter int Width = 32,
  parameter int CntW  = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [4:0]       i_sel,
  input  logic [Width-1:0] i_rs1,
  input  logic [Width-1:0] i_rs2,
  output logic             o_busy,
  output logic             o_done,
  output logic [Width-1:0] o_rd
);

  localparam logic [4:0] SelDiv  = 5'd28;
  localparam logic [4:0] SelDivu = 5'd29;
  localparam logic [4:0] SelRem  = 5'd30;
  localparam logic [4:0] SelRemu = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [Width-1:0]  r_rem;
  logic [Width-1:0]  r_quo;
  logic [Width-1:0]  r_dvs;
  logic              r_is_rem;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_busy;
  logic              r_done;
  logic [Width-1:0]  r_rd;

  logic              w_signed;
  logic              w_is_rem;
  logic              w_valid;
  logic              w_div_zero;
  logic              w_ovf;
  logic [Width-1:0]  w_abs1;
  logic [Width-1:0]  w_abs2;
  logic [Width-1:0]  w_special;
  logic [Width:0]    w_shift;
  logic [Width:0]    w_diff;
  logic              w_ge;
  logic [Width-1:0]  w_rem_next;
  logic [Width-1:0]  w_quo_next;
  logic [Width-1:0]  w_q_fix;
  logic [Width-1:0]  w_r_fix;
  logic [Width-1:0]  w_result;

  // Issue-time decode: operation class, absolute operands, special-case results.
  always_comb begin
    w_signed   = (i_sel == SelDiv) || (i_sel == SelRem);
    w_is_rem   = (i_sel == SelRem) || (i_sel == SelRemu);
    w_valid    = w_signed || (i_sel == SelDivu) || (i_sel == SelRemu);
    w_div_zero = (i_rs2 == {Width{1'b0}});
    w_ovf      = w_signed && (i_rs1 == {1'b1, {(Width-1){1'b0}}})
                          && (i_rs2 == {Width{1'b1}});
    w_abs1     = i_rs1;
    w_abs2     = i_rs2;
    w_special  = {Width{1'b0}};
    if (w_signed && i_rs1[Width-1]) begin
      w_abs1 = ~i_rs1 + Width'(1);
    end else begin
      w_abs1 = i_rs1;
    end
    if (w_signed && i_rs2[Width-1]) begin
      w_abs2 = ~i_rs2 + Width'(1);
    end else begin
      w_abs2 = i_rs2;
    end
    // Divide by zero takes priority; signed overflow cannot have a zero divisor.
    if (!w_valid) begin
      w_special = {Width{1'b0}};
    end else if (w_div_zero) begin
      w_special = w_is_rem ? i_rs1 : {Width{1'b1}};
    end else if (w_ovf) begin
      w_special = w_is_rem ? {Width{1'b0}} : i_rs1;
    end else begin
      w_special = {Width{1'b0}};
    end
  end

  // One restoring step plus the final sign fix-up and result selection.
  always_comb begin
    // Trial subtract is one bit wider than the operands so its sign bit is the borrow.
    w_shift    = {r_rem, r_quo[Width-1]};
    w_diff     = w_shift - {1'b0, r_dvs};
    w_ge       = ~w_diff[Width];
    w_rem_next = w_shift[Width-1:0];
    w_quo_next = {r_quo[Width-2:0], w_ge};
    if (w_ge) begin
      w_rem_next = w_diff[Width-1:0];
    end else begin
      w_rem_next = w_shift[Width-1:0];
    end
    if (r_qneg) begin
      w_q_fix = ~r_quo + Width'(1);
    end else begin
      w_q_fix = r_quo;
    end
    if (r_rneg) begin
      w_r_fix = ~r_rem + Width'(1);
    end else begin
      w_r_fix = r_rem;
    end
    if (r_is_rem) begin
      w_result = w_r_fix;
    end else begin
      w_result = w_q_fix;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CntW{1'b0}};
      r_rem    <= {Width{1'b0}};
      r_quo    <= {Width{1'b0}};
      r_dvs    <= {Width{1'b0}};
      r_is_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd     <= {Width{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy   <= 1'b1;
            r_is_rem <= w_is_rem;
            // Sign flags only matter for the op class that consumes them.
            r_qneg   <= w_signed && !w_is_rem && (i_rs1[Width-1] ^ i_rs2[Width-1]);
            r_rneg   <= w_signed && w_is_rem && i_rs1[Width-1];
            r_rem    <= {Width{1'b0}};
            r_quo    <= w_abs1;
            r_dvs    <= w_abs2;
            r_cnt    <= CntW'(Width - 1);
            if (!w_valid || w_div_zero || w_ovf) begin
              r_rd    <= w_special;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == {CntW{1'b0}}) begin
            r_state <= S_SIGN;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        S_SIGN: begin
          r_rd    <= w_result;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_rd   = r_rd;

endmodule

// File: tb/tb_alu_divider_iterative.sv
// ---------------------------------------------------------------------------
// tb_alu_divider_iterative
//   Directed bench for alu_divider_iterative (Width=32). Expected results
//   and latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_divider_iterative;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  sel;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int n_assert = 0;
  int n_fail   = 0;

  alu_divider_iterative #(.Width(32), .CntW(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_sel   (sel),
    .i_rs1   (rs1),
    .i_rs2   (rs2),
    .o_busy  (busy),
    .o_done  (done),
    .o_rd    (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an operation for one cycle, then scramble the operand inputs.
  task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    sel   = 5'd0;
    rs1   = ~a;
    rs2   = b ^ 32'h5A5A_5A5A;
  endtask

  task automatic run_op(input string tag, input logic [4:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit busy_ok;
    bit seen;
    lat     = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    issue(s, a, b);
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rd"}, rd, exp);
    check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, " done drops"}, {31'd0, done}, 32'd0);
    check({tag, " busy drops"}, {31'd0, busy}, 32'd0);
    check({tag, " rd held"}, rd, exp);
  endtask

  initial begin
    int dones;
    int first;
    logic [31:0] rd_seen;

    rst_n = 1'b0;
    start = 1'b0;
    sel   = 5'd0;
    rs1   = 32'd0;
    rs2   = 32'd0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset rd", rd, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("divu 100/7", 5'd29, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu 100%7", 5'd31, 32'd100, 32'd7, 32'd2, 34);
    run_op("div -100/7", 5'd28, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
    run_op("rem -100%7", 5'd30, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
    run_op("rem 100%-7", 5'd30, 32'd100, 32'hFFFF_FFF9, 32'd2, 34);
    run_op("div 100/-7", 5'd28, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run_op("div 5/0", 5'd28, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu 0x1234%0", 5'd31, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    run_op("div ovf", 5'd28, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", 5'd30, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu min/-1", 5'd29, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run_op("sel0", 5'd0, 32'd123, 32'd4, 32'd0, 1);

    // START during a running DIVU, with operands toggling, must be ignored.
    issue(5'd29, 32'd1000, 32'd9);
    dones   = 0;
    first   = 0;
    rd_seen = 32'd0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (first == 0) begin
          first   = c;
          rd_seen = rd;
        end
      end
      start = (c == 10);
      sel   = 5'd28;
      rs1   = $urandom;
      rs2   = $urandom_range(0, 3);
    end
    start = 1'b0;
    check("ignored start done count", 32'(dones), 32'd1);
    check("ignored start latency", 32'(first), 32'd34);
    check("ignored start rd", rd_seen, 32'd111);

    // Asynchronous reset in the middle of a DIV aborts it with no DONE.
    issue(5'd28, 32'hFFFF_FF9C, 32'd7);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort rd", rd, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("no done after abort", 32'(dones), 32'd0);

    run_op("divu max/1", 5'd29, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
